// File: rtl/stepper_driver_if.sv
// Processor-side bundle for the stepper driver: target/delay/enable in, coil drive and status out.
interface stepper_driver_if;
   logic       enable;
   logic [7:0] position;
   logic [7:0] delay;
   logic [3:0] coils;
   logic [7:0] cur_pos;
   logic       busy;
   logic       step;
   logic       dir;
   logic       done;

   modport master (
      output enable, position, delay,
      input  coils, cur_pos, busy, step, dir, done
   );

   modport slave (
      input  enable, position, delay,
      output coils, cur_pos, busy, step, dir, done
   );
endinterface

// File: rtl/stepper_driver.sv
// Unipolar 4-wire stepper sequencer: steps cur_pos toward position, one step per delay period.
// Define STEPPER_HALF_STEP_EN for the 8-entry half-step sequence (cur_pos then counts half-steps).
//
// state  | meaning
// S_IDLE | stopped, coils hold last pattern; accepts a move when enabled and off target
// S_WAIT | inter-step delay: prescaler x dcount countdown, aborts or finishes early
// S_STEP | single cycle that advances cur_pos/phase and drives the new coil pattern
module stepper_driver #(
   parameter int unsigned TICKS_PER_UNIT = 50000,
   parameter int unsigned PRESCALE_W     = 20
) (
   input logic             clk,
   input logic             reset_n,
   stepper_driver_if.slave bus
);

`ifdef STEPPER_HALF_STEP_EN
   localparam int PH_W = 3;
`else
   localparam int PH_W = 2;
`endif

   localparam logic [PRESCALE_W-1:0] PRE_RELOAD = PRESCALE_W'(TICKS_PER_UNIT - 1);
   localparam logic [PRESCALE_W-1:0] PRE_ONE    = PRESCALE_W'(1);
   localparam logic [PH_W-1:0]       PH_ONE     = PH_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_STEP = 2'd2
   } state_t;

   function automatic logic [3:0] f_pattern(input logic [PH_W-1:0] idx);
      logic [3:0] pat;
      pat = 4'b0001;
`ifdef STEPPER_HALF_STEP_EN
      case (idx)
         3'd0: pat = 4'b0001;
         3'd1: pat = 4'b0011;
         3'd2: pat = 4'b0010;
         3'd3: pat = 4'b0110;
         3'd4: pat = 4'b0100;
         3'd5: pat = 4'b1100;
         3'd6: pat = 4'b1000;
         3'd7: pat = 4'b1001;
      endcase
`else
      case (idx)
         2'd0: pat = 4'b0001;
         2'd1: pat = 4'b0010;
         2'd2: pat = 4'b0100;
         2'd3: pat = 4'b1000;
      endcase
`endif
      return pat;
   endfunction

   state_t                r_state;
   logic [7:0]            r_cur_pos;
   logic [PH_W-1:0]       r_phase;
   logic [3:0]            r_coils;
   logic                  r_busy;
   logic                  r_step;
   logic                  r_dir;
   logic                  r_done;
   logic [7:0]            r_dcount;
   logic [PRESCALE_W-1:0] r_prescale;

   logic                  w_pos_gt;
   logic                  w_pos_eq;
   logic [7:0]            w_dcount_load;
   logic [7:0]            w_step_pos;
   logic [PH_W-1:0]       w_step_phase;

   assign w_pos_gt      = (bus.position > r_cur_pos);
   assign w_pos_eq      = (bus.position == r_cur_pos);
   assign w_dcount_load = (bus.delay == 8'd0) ? 8'd1 : bus.delay;
   assign w_step_pos    = w_pos_gt ? (r_cur_pos + 8'd1) : (r_cur_pos - 8'd1);
   assign w_step_phase  = w_pos_gt ? (r_phase + PH_ONE) : (r_phase - PH_ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cur_pos  <= 8'd0;
         r_phase    <= '0;
         r_coils    <= 4'b0001;
         r_busy     <= 1'b0;
         r_step     <= 1'b0;
         r_dir      <= 1'b0;
         r_done     <= 1'b0;
         r_dcount   <= 8'd0;
         r_prescale <= '0;
      end else begin
         r_step <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.enable && !w_pos_eq) begin
                  r_state    <= S_WAIT;
                  r_busy     <= 1'b1;
                  r_dcount   <= w_dcount_load;
                  r_prescale <= PRE_RELOAD;
                  r_dir      <= w_pos_gt;
               end
            end
            S_WAIT: begin
               if (!bus.enable) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_pos_eq) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (r_prescale == '0 && r_dcount == 8'd1) begin
                  r_state <= S_STEP;
               end else if (r_prescale == '0) begin
                  r_prescale <= PRE_RELOAD;
                  r_dcount   <= r_dcount - 8'd1;
               end else begin
                  r_prescale <= r_prescale - PRE_ONE;
               end
            end
            S_STEP: begin
               // A retarget onto cur_pos during this cycle ends the move rather than stepping away
               if (w_pos_eq) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_dir     <= w_pos_gt;
                  r_cur_pos <= w_step_pos;
                  r_phase   <= w_step_phase;
                  r_coils   <= f_pattern(w_step_phase);
                  r_step    <= 1'b1;
                  if (w_step_pos == bus.position) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_WAIT;
                     r_dcount   <= w_dcount_load;
                     r_prescale <= PRE_RELOAD;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.coils   = r_coils;
   assign bus.cur_pos = r_cur_pos;
   assign bus.busy    = r_busy;
   assign bus.step    = r_step;
   assign bus.dir     = r_dir;
   assign bus.done    = r_done;

endmodule
